// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    // Instruction word that stops fetching once decode accepts it.
    localparam logic [31:0] HALT_INSTR = 32'h0000_0021;

    // Primary opcode field values used by the surrounding pipeline.
    localparam logic [5:0] OP_BEQ = 6'b000110;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_LW  = 6'b000100;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump > taken branch > sequential.
module next_pc_calc #(
    parameter int N = 32
) (
    input  logic [N-1:0] pc,
    input  logic         jump,
    input  logic [25:0]  jump_target,
    input  logic         branch_taken,
    input  logic [15:0]  branch_offset,
    output logic [N-1:0] next_pc
);

    logic [N-1:0] pc4;
    logic [N-1:0] branch_disp;
    logic [N-1:0] branch_pc;
    logic [N-1:0] jump_pc;

    assign pc4 = pc + N'(4);

    // Sign-extended word offset already scaled to bytes; the top bits lost
    // by the shift are dropped, which keeps the sum modulo 2^N.
    assign branch_disp = {{(N-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign branch_pc   = pc4 + branch_disp;

    // Jump keeps the region bits of the sequential address.
    assign jump_pc = {pc4[N-1:28], jump_target, 2'b00};

    // Priority select of the redirect source.
    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Zero-latency instruction fetch sequencer with IDLE/RUN/HALT control.
// Optional macro FETCH_STATS_EN adds fetch_count and redirect_count outputs.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int          N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int unsigned PC_LIMIT = 512
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] imem_addr,
    input  logic [N-1:0] imem_instr,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    input  logic         branch_taken,
    input  logic [15:0]  branch_offset,
    input  logic         jump,
    input  logic [25:0]  jump_target,
    output logic         done,
    output logic         fault
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]  fetch_count,
    output logic [31:0]  redirect_count
`endif
);

    localparam logic [N-1:0] PC_LAST = N'(PC_LIMIT - 4);

    state_t       state, state_nxt;
    logic [N-1:0] pc, pc_nxt, calc_pc;
    logic         done_nxt, fault_nxt;
    logic         pc_oob, transfer, is_halt;

    next_pc_calc #(.N(N)) u_next_pc (
        .pc            (pc),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .next_pc       (calc_pc)
    );

    assign pc_oob      = (pc > PC_LAST);
    assign instr_valid = (state == RUN) && !pc_oob;
    assign transfer    = instr_valid && instr_ready;
    assign is_halt     = (imem_instr == N'(HALT_INSTR));
    assign imem_addr   = pc;
    assign instr_pc    = pc;
    assign instr       = instr_valid ? imem_instr : '0;

    // Next-state, next-PC and sticky status decisions.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_nxt = state;
        pc_nxt    = pc;
        done_nxt  = done;
        fault_nxt = fault;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (pc_oob) begin
                    state_nxt = HALT;
                    fault_nxt = 1'b1;
                end else if (transfer) begin
                    if (is_halt) begin
                        state_nxt = HALT;
                        done_nxt  = 1'b1;
                    end else begin
                        pc_nxt = calc_pc;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, PC and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            done  <= 1'b0;
            fault <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            done  <= done_nxt;
            fault <= fault_nxt;
        end
    end

`ifdef FETCH_STATS_EN
    logic take_redirect;
    assign take_redirect = transfer && !is_halt && (jump || branch_taken);

    // Transfer and redirect statistics, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (transfer)      fetch_count    <= fetch_count + 32'd1;
            if (take_redirect) redirect_count <= redirect_count + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning address and instruction width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the PC loaded on reset.
REQ-003 SHALL have parameter PC_LIMIT, default 512, meaning the instruction memory size in bytes; the last legal PC is PC_LIMIT-4.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, which leaves IDLE.
REQ-007 SHALL have port imem_addr, output, N, the instruction memory address (equals pc).
REQ-008 SHALL have port imem_instr, input, N, the combinational read data from instruction memory.
REQ-009 SHALL have port instr, output, N, the instruction presented to decode.
REQ-010 SHALL have port instr_pc, output, N, the address of instr.
REQ-011 SHALL have port instr_valid, output, 1, high when instr is valid.
REQ-012 SHALL have port instr_ready, input, 1, decode acceptance.
REQ-013 SHALL have port branch_taken, input, 1, the execute-stage beq outcome for the instruction being transferred.
REQ-014 SHALL have port branch_offset, input, 16, the signed word offset.
REQ-015 SHALL have port jump, input, 1, the jump request.
REQ-016 SHALL have port jump_target, input, 26, the word target field.
REQ-017 SHALL have port done, output, 1, high when a halt instruction was retired.
REQ-018 SHALL have port fault, output, 1, high when an out-of-range PC was reached.

Function
REQ-019 SHALL implement states IDLE, RUN and HALT; reset state IDLE.
REQ-020 IDLE SHALL drive instr_valid=0 and move to RUN on the first cycle start=1.
REQ-021 RUN SHALL drive instr=imem_instr, instr_pc=pc and instr_valid=1 in the same cycle (zero-latency fetch).
REQ-022 A transfer SHALL occur when instr_valid&instr_ready; without a transfer, pc and all outputs SHALL hold (stall), and branch_taken/jump SHALL be ignored.
REQ-023 On a transfer, next pc SHALL be selected with priority jump > branch_taken > sequential:
- jump: {pc4[31:28], jump_target, 2'b00}
- branch: pc4 + (sext(branch_offset) << 2), computed modulo 2^N
- sequential: pc4, where pc4 = pc+4
REQ-024 On a transfer where instr==32'h0000_0021 (halt marker), the sequencer SHALL go to HALT with done=1 and pc held; any redirect in that cycle SHALL be ignored.
REQ-025 If pc > PC_LIMIT-4 while in RUN, the sequencer SHALL assert instr_valid=0 in that cycle and go to HALT with fault=1 on the next edge.
REQ-026 HALT SHALL keep instr_valid=0 and ignore start; only reset SHALL exit HALT.
REQ-027 done and fault SHALL be registered and sticky until reset.

Reset
REQ-028 On reset=1 at a clock edge, including mid-RUN or during a stall, the following SHALL take effect on that edge and have priority over all other inputs:
- state=IDLE, pc=RESET_PC
- instr_valid=0, instr=0, instr_pc=RESET_PC
- done=0, fault=0

Configuration
REQ-029 With macro FETCH_STATS_EN defined, the block SHALL add output fetch_count (32 bits, reset 0), incremented once per transfer, wrapping at 2^32.
REQ-030 With FETCH_STATS_EN defined, the block SHALL add output redirect_count (32 bits, reset 0), incremented once per transfer that takes a jump or branch.
REQ-031 Without FETCH_STATS_EN, neither port nor counter SHALL exist.

Structure
REQ-032 Package fetch_pkg SHALL hold the state enum, HALT_INSTR=32'h0000_0021 and the opcode constants (beq 6'b000110, j 6'b000010, lw 6'b000100).
REQ-033 Next-PC arithmetic SHALL be a combinational sub-module next_pc_calc; the state machine and counters SHALL stay in fetch_sequencer.

Verification
REQ-034 Reset, then start=1, instr_ready=1, no redirects: imem_addr SHALL step 0,4,8,12 on consecutive cycles.
REQ-035 With pc=8, branch_taken=1, branch_offset=2 on the transfer: the next pc SHALL be 20; repeating with offset=16'hFFFF SHALL give pc 8.
REQ-036 With pc=16, jump=1, jump_target=6 and branch_taken=1 together: the next pc SHALL be 24 (jump wins).
REQ-037 With instr_ready=0 for 3 cycles at pc=28 and branch_taken pulsed: pc SHALL hold 28 and instr SHALL stay stable; ready=1 then SHALL advance to 32.
REQ-038 Halt marker at pc=84: after its transfer, done=1, instr_valid=0 and pc=84 SHALL hold; then reset=1 SHALL clear done and give IDLE with pc=0.
REQ-039 Jump to word 200 (pc 800, beyond PC_LIMIT=512): instr_valid=0 that cycle, fault=1 on the next edge; with FETCH_STATS_EN, fetch_count SHALL equal the number of transfers.
